// File: rtl/keypad_scanner_pkg.sv
// Shared matrix geometry, frame layout and key encoding helpers for the
// keypad scanner and the display-select logic that consumes its codes.
package keypad_scanner_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int KEY_W    = 4;
  localparam int FRAME_W  = NUM_ROWS * NUM_COLS;
  // Frame bit for key (r,c) sits at c*COL_STRIDE + r; key code is r*NUM_COLS + c.
  localparam int COL_STRIDE = NUM_ROWS;

  typedef logic [NUM_COLS-1:0][NUM_ROWS-1:0] frame_t;
  typedef logic [KEY_W-1:0]                  key_code_t;

  function automatic logic one_hot(input frame_t f);
    logic [FRAME_W-1:0] v;
    v = f;
    return (v != '0) && ((v & (v - FRAME_W'(1))) == '0);
  endfunction

  function automatic key_code_t encode(input frame_t f);
    logic [FRAME_W-1:0] v;
    key_code_t code;
    v = f;
    code = '0;
    for (int c = 0; c < NUM_COLS; c++)
      for (int r = 0; r < NUM_ROWS; r++)
        if (v[c*COL_STRIDE + r]) code = KEY_W'(r*NUM_COLS + c);
    return code;
  endfunction
endpackage

// File: rtl/keypad_scanner_if.sv
// Matrix lines plus the key report bus; master is the scanner.
interface keypad_scanner_if;
  import keypad_scanner_pkg::*;
  logic [NUM_ROWS-1:0] row;
  logic [NUM_COLS-1:0] col;
  key_code_t           key_code;
  logic                key_valid;
  logic                key_down;

  modport master (input row, output col, key_code, key_valid, key_down);
  modport slave  (output row, input col, key_code, key_valid, key_down);
endinterface

// File: rtl/keypad_scanner_debounce.sv
// Frame debouncer: a frame must repeat DEBOUNCE_FRAMES times in a row before
// it replaces the stable frame; accept is a same-cycle strobe with frame_done.
module keypad_debounce
  import keypad_scanner_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  frame_t frame,
  input  logic   frame_done,
  output frame_t stable,
  output logic   accept
);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);

  frame_t     prev;
  logic [3:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (frame_done) begin
      if (frame == prev) cnt_nxt = (cnt >= DEB) ? DEB : cnt + 4'd1;
      else               cnt_nxt = 4'd1;
    end
    // Re-reaching the count on a frame already held as stable is a no-op.
    accept = frame_done && (cnt_nxt == DEB) && (frame != stable);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (frame_done) prev   <= frame;
      if (accept)     stable <= frame;
    end
  end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: strobes columns, synchronises rows, assembles a
// 16-key frame per scan and reports debounced single-key presses.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int CLK_FREQ        = 12_000_000,
  parameter int SCAN_HZ         = 1000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input logic               clk,
  input logic               rst_n,
  keypad_scanner_if.master  kif
);
  localparam int              P        = CLK_FREQ / SCAN_HZ;
  localparam int              CW       = $clog2(P);
  localparam int              IW       = $clog2(NUM_COLS);
  localparam logic [CW-1:0]   LAST     = CW'(P - 1);
  localparam logic [IW-1:0]   LAST_COL = IW'(NUM_COLS - 1);

  logic [NUM_ROWS-1:0] row_s1, row_s2;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  frame_t              frame, frame_nxt, stable;
  logic                sample, frame_done, accept;

  assign sample     = (cnt == LAST);
  assign frame_done = sample && (idx == LAST_COL);
  assign kif.col    = ~(NUM_COLS'(1) << idx);

  // The column-3 sample is merged here so the debouncer sees the whole frame
  // on the same edge that completes it.
  always_comb begin
    frame_nxt = frame;
    if (sample) frame_nxt[idx] = ~row_s2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
      cnt    <= '0;
      idx    <= '0;
      frame  <= '0;
    end else begin
      row_s1 <= kif.row;
      row_s2 <= row_s1;
      frame  <= frame_nxt;
      if (sample) begin
        cnt <= '0;
        idx <= (idx == LAST_COL) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  keypad_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame      (frame_nxt),
    .frame_done (frame_done),
    .stable     (stable),
    .accept     (accept)
  );

  // Only an idle-to-single-key transition counts as a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kif.key_code  <= '0;
      kif.key_valid <= 1'b0;
      kif.key_down  <= 1'b0;
    end else begin
      kif.key_valid <= 1'b0;
      if (accept) begin
        kif.key_down <= (frame_nxt != '0);
        if (stable == '0 && one_hot(frame_nxt)) begin
          kif.key_code  <= encode(frame_nxt);
          kif.key_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench with a matrix model and a key-code scoreboard.
module tb_keypad_scanner;
  import keypad_scanner_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  keypad_scanner_if kif();

  keypad_scanner #(.CLK_FREQ(1000), .SCAN_HZ(100), .DEBOUNCE_FRAMES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kif   (kif)
  );

  logic [3:0][3:0] held = '0;  // [row][col]
  int asserts = 0, fails = 0, pulses = 0;
  key_code_t exp_q[$];

  // row[r] is pulled low when its key on the driven column is held
  always_comb begin
    kif.row = '1;
    for (int r = 0; r < 4; r++)
      if ((held[r] & ~kif.col) != 4'b0) kif.row[r] = 1'b0;
  end

  task automatic check(input string name, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (kif.key_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL unexpected key_valid: code %0d at %0t", kif.key_code, $time);
      end else begin
        check("key_code on valid", int'(kif.key_code), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int start, input int budget, input string name, output int n);
    n = 0;
    while (pulses == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    asserts++;
    if (pulses == start) begin
      fails++;
      $display("FAIL %s: no key_valid within %0d cycles", name, budget);
    end
  endtask

  task automatic check_outs(input string name, input int code, input int down);
    check({name, " key_code"}, int'(kif.key_code), code);
    check({name, " key_down"}, int'(kif.key_down), down);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, start, idx;
    // Reset state and column stepping
    idle(3);
    check("reset col", int'(kif.col), 14);
    check_outs("reset", 0, 0);
    check("reset key_valid", int'(kif.key_valid), 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k % 10 == 0 || k % 10 == 9) begin
        idx = (k / 10) % 4;
        check($sformatf("col after %0d cycles", k), int'(kif.col), 15 ^ (1 << idx));
      end
    end
    check_outs("idle scan", 0, 0);

    // Single press (2,1) held 300 cycles
    idle(5);
    start = pulses;
    exp_q.push_back(4'd9);
    held[2][1] = 1'b1;
    wait_pulse(start, 5*40+3, "press (2,1)", n);
    @(negedge clk);
    check_outs("press (2,1)", 9, 1);
    idle(300 - n - 2);
    check("key_down before release", int'(kif.key_down), 1);
    held[2][1] = 1'b0;
    idle(220);
    check_outs("release (2,1)", 9, 0);
    check("pulses for (2,1)", pulses, start + 1);

    // Bounce on (0,3), then hold
    start = pulses;
    exp_q.push_back(4'd3);
    for (int i = 0; i < 8; i++) begin
      held[0][3] = ~held[0][3];
      idle(25);
    end
    check("no pulse while bouncing", pulses, start);
    held[0][3] = 1'b1;
    wait_pulse(start, 5*40+3, "press (0,3)", n);
    @(negedge clk);
    check_outs("press (0,3)", 3, 1);
    held[0][3] = 1'b0;
    idle(220);
    check_outs("release (0,3)", 3, 0);

    // Two keys together
    start = pulses;
    held[1][0] = 1'b1;
    held[3][3] = 1'b1;
    idle(250);
    check_outs("two keys", 3, 1);
    check("no pulse on two keys", pulses, start);
    held = '0;
    idle(220);
    check_outs("release two keys", 3, 0);

    // Hold (0,0), add (2,2), release (0,0)
    start = pulses;
    exp_q.push_back(4'd0);
    held[0][0] = 1'b1;
    wait_pulse(start, 5*40+3, "press (0,0)", n);
    @(negedge clk);
    check_outs("press (0,0)", 0, 1);
    held[2][2] = 1'b1;
    idle(220);
    check_outs("add (2,2)", 0, 1);
    held[0][0] = 1'b0;
    idle(220);
    check_outs("drop (0,0)", 0, 1);
    check("only one pulse in rollover", pulses, start + 1);
    held[2][2] = 1'b0;
    idle(220);
    check_outs("release (2,2)", 0, 0);

    // Reset during a held press of (1,2)
    start = pulses;
    exp_q.push_back(4'd6);
    held[1][2] = 1'b1;
    wait_pulse(start, 5*40+3, "press (1,2)", n);
    idle(23);
    check_outs("before reset", 6, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset col", int'(kif.col), 14);
    check_outs("mid reset", 0, 0);
    check("mid reset key_valid", int'(kif.key_valid), 0);
    idle(3);
    rst_n = 1'b1;
    start = pulses;
    exp_q.push_back(4'd6);
    idle(2);
    check("no pulse on reset release", pulses, start);
    wait_pulse(start, 5*40+3, "press (1,2) after reset", n);
    @(negedge clk);
    check_outs("after reset", 6, 1);
    held = '0;
    idle(220);
    check_outs("final release", 6, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 passive key matrix by driving one column low at a time and sampling the row lines, debounces the resulting 16-key frame and reports single-key presses as a 4-bit code with a one-cycle valid strobe. It is the input-side counterpart of the multiplexed seven-segment driver. It shares the same column-strobing time base idea and sits beside it in the top level, feeding key codes to the display-select logic.

## Interface
- `CLK_FREQ`, 12_000_000: system clock frequency in Hz.
- `SCAN_HZ`, 1000: column advance rate in Hz; column period `P = CLK_FREQ/SCAN_HZ` cycles; P >= 4 required.
- `DEBOUNCE_FRAMES`, 4: consecutive identical frames required before a frame is accepted as stable (1..15).
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `row` input 4: matrix row lines, active-low (external pull-ups), asynchronous to `clk`.
- `col` output 4: column drive, active-low one-hot; inactive columns driven high.
- `key_code` output 4: code of last accepted press = row_idx*4 + col_idx.
- `key_valid` output 1: one-cycle pulse when `key_code` is updated.
- `key_down` output 1: high while the stable frame has any key pressed.

## Operation
- Reset values: `col`=4'b1110 (column 0), `key_code`=0, `key_valid`=0, `key_down`=0; synchroniser, frame, stable, and debounce state all cleared (no keys).
- `row` passes through a 2-flop synchroniser before any use.
- Column counter `P` cycles per column; column index 0→1→2→3→0, `col` = ~(1<<idx).
- Sample: on the last cycle of each column period (count == P-1), synchronised rows (inverted, 1 = pressed) are written into frame bits [idx*4 +: 4], bit = col_idx*4 + row_idx. Settling of the column plus 2-flop latency is covered because P >= 4.
- Frame complete on the sample of column 3. The completed 16-bit frame is compared with the previous completed frame:
  - equal: debounce counter increments, saturating at DEBOUNCE_FRAMES;
  - different: counter resets to 1.
- Accept: when the counter reaches DEBOUNCE_FRAMES and frame != stable, stable <= frame.
- On accept:
  - `key_down` <= (stable != 0).
  - If the old stable was 0 and the new stable has exactly one bit set, `key_code` <= row_idx*4 + col_idx of that bit and `key_valid` pulses.
  - Otherwise (release, multi-key, or key added or removed while another key is held), no pulse and `key_code` holds.
- Multi-key rollover is not supported. Releasing back to one key from two does not generate a press.

## Timing
- Frame length 4P cycles. `key_valid` is asserted the cycle after the accepting sample edge.
- Press latency from a stable `row` change: at most (DEBOUNCE_FRAMES+1)*4P + 3 cycles.
- `key_valid` is high for exactly one cycle. It is never asserted in consecutive cycles; minimum spacing is 4P cycles.
- A bounce that differs in any frame restarts the count. A frame identical to the current stable state never re-accepts.
- Reset mid-scan returns to column 0 with count 0 immediately (async). No pulse is generated on reset release even if a key is held; the held key is reported after debounce as a new press.
- Counter arithmetic: column counter width clog2(P), debounce counter 4 bits.

## Structure
- Shared package/header: NUM_ROWS=4, NUM_COLS=4, key-code width 4, and a localparam for the row/column bit mapping used by both this block and the display-select logic.
- One sub-module: `keypad_debounce`. Its inputs are the frame and frame-done strobe; its outputs are the stable frame and an accept strobe. It holds the compare register and counter. The top level keeps the scan counter, synchroniser, and press encoding.

## Test plan
Parameters for the bench: CLK_FREQ=1000, SCAN_HZ=100 (P=10), DEBOUNCE_FRAMES=4. The bench models the matrix: `row[r]` = 0 iff `col[c]`=0 and key (r,c) is held.
- Reset: hold `rst_n`=0, then release. `col` steps 1110→1101→1011→0111 at cycles 10, 20, 30 and wraps at cycle 40. Outputs stay 0, no `key_valid`.
- Single press of key (row 2, col 1) held for 300 cycles: exactly one `key_valid`, with `key_code`=9, within 5*40+3 cycles. `key_down`=1 until the debounced release.
- Bounce: key (0,3) toggled every 25 cycles for 200 cycles, then held. No pulse during bouncing, one pulse with `key_code`=3 after the hold is debounced.
- Two keys (1,0) and (3,3) pressed together: `key_down`=1, no `key_valid`, `key_code` unchanged.
- Hold (0,0), then add (2,2), then release (0,0): only one pulse (code 0), no pulse for (2,2).
- Assert `rst_n` low mid-press for 3 cycles: `col`=1110 and all outputs 0 immediately. After release, the held key pulses again after debounce.
